fetch_unit: RTL and testbench

- Instruction-fetch stage sitting directly upstream of the multi-cycle control FSM.
- Owns the PC register and the instruction register (IR).
- Fetches a 32-bit instruction from instruction memory over a req/ack handshake when the control FSM asserts LOAD_IR, and loads the PC on WRITE_PC.
- Presents INSTRUCAO and op_code to the control FSM, and PC / PC_OLD to the ALU operand muxes.

---
 rtl/fetch_unit.sv | 111 +++++++++++
 tb/tb_fetch_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns PC, PC_OLD and IR, fetches over a req/ack handshake.
// Optional macro MISALIGN_TRAP_EN traps LOAD_IR on a PC that is not word aligned.
module fetch_unit #(
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     MAX_WAIT = 15
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            LOAD_IR,
  input  logic            WRITE_PC,
  input  logic [XLEN-1:0] PC_IN,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [31:0]     mem_rdata,
  output logic [31:0]     INSTRUCAO,
  output logic [6:0]      op_code,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PC_OLD,
  output logic            instr_valid,
  output logic            busy,
  output logic            fetch_err,
  output logic            misalign
);

  typedef enum logic [1:0] {StIdle, StReq, StErr} state_e;

  localparam logic [31:0] IrReset  = 32'h0000_0013;
  localparam logic [7:0]  WaitLast = 8'(MAX_WAIT - 1);

  state_e          state_q;
  logic [7:0]      cnt_q;
  logic [XLEN-1:0] pc_q, pc_old_q, mem_addr_q;
  logic [31:0]     ir_q;
  logic            mem_req_q, busy_q, instr_valid_q, fetch_err_q, misalign_q;
  logic            misaligned;

`ifdef MISALIGN_TRAP_EN
  assign misaligned = (pc_q[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      pc_q          <= RESET_PC;
      pc_old_q      <= RESET_PC;
      mem_addr_q    <= '0;
      ir_q          <= IrReset;
      mem_req_q     <= 1'b0;
      busy_q        <= 1'b0;
      instr_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      instr_valid_q <= 1'b0;
      // PC write is independent of the fetch; a same-edge fetch still sees the old pc_q
      if (WRITE_PC) pc_q <= PC_IN;
      case (state_q)
        StIdle: begin
          if (LOAD_IR) begin
            pc_old_q <= pc_q;
            if (misaligned) begin
              misalign_q <= 1'b1;
              state_q    <= StErr;
            end else begin
              mem_addr_q <= pc_q;
              mem_req_q  <= 1'b1;
              busy_q     <= 1'b1;
              cnt_q      <= '0;
              state_q    <= StReq;
            end
          end
        end
        StReq: begin
          if (mem_ack) begin
            ir_q          <= mem_rdata;
            mem_req_q     <= 1'b0;
            busy_q        <= 1'b0;
            instr_valid_q <= 1'b1;
            state_q       <= StIdle;
          end else if (cnt_q == WaitLast) begin
            mem_req_q   <= 1'b0;
            busy_q      <= 1'b0;
            fetch_err_q <= 1'b1;
            state_q     <= StErr;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StErr:   ;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign INSTRUCAO   = ir_q;
  assign op_code     = ir_q[6:0];
  assign PC          = pc_q;
  assign PC_OLD      = pc_old_q;
  assign instr_valid = instr_valid_q;
  assign busy        = busy_q;
  assign fetch_err   = fetch_err_q;
  assign misalign    = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory responder driven from a scoreboard of expected
// fetch addresses and instruction words.
module tb_fetch_unit;

  localparam int unsigned XLEN = 64;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic            LOAD_IR = 1'b0;
  logic            WRITE_PC = 1'b0;
  logic [XLEN-1:0] PC_IN = '0;
  logic            mem_ack = 1'b0;
  logic [31:0]     mem_rdata = '0;
  logic            mem_req, instr_valid, busy, fetch_err, misalign;
  logic [XLEN-1:0] mem_addr, PC, PC_OLD;
  logic [31:0]     INSTRUCAO;
  logic [6:0]      op_code;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] instr;
  } exp_t;
  exp_t sb[$];

  fetch_unit #(.XLEN(64), .RESET_PC(64'h0), .MAX_WAIT(15)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .LOAD_IR    (LOAD_IR),
    .WRITE_PC   (WRITE_PC),
    .PC_IN      (PC_IN),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .INSTRUCAO  (INSTRUCAO),
    .op_code    (op_code),
    .PC         (PC),
    .PC_OLD     (PC_OLD),
    .instr_valid(instr_valid),
    .busy       (busy),
    .fetch_err  (fetch_err),
    .misalign   (misalign)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic [63:0] a, input logic [31:0] d);
    exp_t e;
    e.addr  = a;
    e.instr = d;
    sb.push_back(e);
    LOAD_IR = 1'b1;
    step();
    LOAD_IR = 1'b0;
  endtask

  // Memory model: hold off for 'waits' cycles, then return the scoreboard's word.
  task automatic respond(input int waits);
    exp_t e;
    for (int i = 0; i < waits; i++) begin
      chk("wait_req", 64'(mem_req), 64'd1);
      chk("wait_addr", mem_addr, sb[0].addr);
      step();
    end
    chk("ack_req", 64'(mem_req), 64'd1);
    chk("ack_addr", mem_addr, sb[0].addr);
    mem_ack   = 1'b1;
    mem_rdata = sb[0].instr;
    step();
    mem_ack   = 1'b0;
    mem_rdata = '0;
    e = sb.pop_front();
    chk("valid_pulse", 64'(instr_valid), 64'd1);
    chk("ir", 64'(INSTRUCAO), 64'(e.instr));
    chk("op_code", 64'(op_code), 64'(e.instr[6:0]));
    chk("req_drop", 64'(mem_req), 64'd0);
    chk("busy_drop", 64'(busy), 64'd0);
    step();
    chk("valid_end", 64'(instr_valid), 64'd0);
  endtask

  task automatic set_pc(input logic [63:0] v);
    WRITE_PC = 1'b1;
    PC_IN    = v;
    step();
    WRITE_PC = 1'b0;
  endtask

  initial begin
    int n;
    #12;
    chk("rst_pc", PC, 64'h0);
    chk("rst_pc_old", PC_OLD, 64'h0);
    chk("rst_ir", 64'(INSTRUCAO), 64'h13);
    chk("rst_op", 64'(op_code), 64'h13);
    chk("rst_req", 64'(mem_req), 64'd0);
    chk("rst_addr", mem_addr, 64'h0);
    chk("rst_valid", 64'(instr_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(fetch_err), 64'd0);
    chk("rst_mis", 64'(misalign), 64'd0);
    @(negedge CLK);
    RST = 1'b0;
    step();

    // Fetch and PC write on the same edge, zero-wait memory
    WRITE_PC = 1'b1;
    PC_IN    = 64'd4;
    issue(64'd0, 32'h0050_0093);
    WRITE_PC = 1'b0;
    chk("t1_pc", PC, 64'd4);
    chk("t1_pc_old", PC_OLD, 64'd0);
    chk("t1_busy", 64'(busy), 64'd1);
    respond(0);

    // Ack while idle must not touch IR
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_ack   = 1'b0;
    chk("idle_ack_ir", 64'(INSTRUCAO), 64'h0050_0093);
    chk("idle_ack_valid", 64'(instr_valid), 64'd0);

    // Three wait cycles
    set_pc(64'd8);
    issue(64'd8, 32'h0020_81B3);
    respond(3);
    chk("t2_pc_old", PC_OLD, 64'd8);

    // PC write and repeated LOAD_IR during REQ
    set_pc(64'd12);
    issue(64'd12, 32'h00C5_8633);
    WRITE_PC = 1'b1;
    PC_IN    = 64'd40;
    LOAD_IR  = 1'b1;
    step();
    WRITE_PC = 1'b0;
    LOAD_IR  = 1'b0;
    chk("t5_addr", mem_addr, 64'd12);
    chk("t5_pc", PC, 64'd40);
    chk("t5_pc_old", PC_OLD, 64'd12);
    respond(1);
    for (int i = 0; i < 3; i++) chk("t5_no_second", 64'(mem_req), 64'd0);
    chk("t5_sb_empty", 64'(sb.size()), 64'd0);

    // Asynchronous reset mid-fetch
    LOAD_IR = 1'b1;
    step();
    LOAD_IR = 1'b0;
    chk("ar_req_up", 64'(mem_req), 64'd1);
    #3 RST = 1'b1;
    #1;
    chk("ar_req", 64'(mem_req), 64'd0);
    chk("ar_pc", PC, 64'h0);
    chk("ar_busy", 64'(busy), 64'd0);
    @(negedge CLK);
    RST = 1'b0;
    step();

    // Timeout with no ack
    set_pc(64'd20);
    LOAD_IR = 1'b1;
    step();
    LOAD_IR = 1'b0;
    n = 0;
    while (mem_req === 1'b1 && n < 40) begin
      n++;
      step();
    end
    chk("to_cycles", 64'(n), 64'd15);
    chk("to_err", 64'(fetch_err), 64'd1);
    chk("to_busy", 64'(busy), 64'd0);
    LOAD_IR = 1'b1;
    step();
    LOAD_IR = 1'b0;
    chk("err_no_req", 64'(mem_req), 64'd0);
    step();
    chk("err_no_req2", 64'(mem_req), 64'd0);
    chk("err_sticky", 64'(fetch_err), 64'd1);
    set_pc(64'd44);
    chk("err_pc_write", PC, 64'd44);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    chk("err_cleared", 64'(fetch_err), 64'd0);
    @(negedge CLK);
    RST = 1'b0;
    step();

    // Misaligned fetch
    set_pc(64'd6);
`ifdef MISALIGN_TRAP_EN
    LOAD_IR = 1'b1;
    step();
    LOAD_IR = 1'b0;
    chk("mis_req", 64'(mem_req), 64'd0);
    chk("mis_flag", 64'(misalign), 64'd1);
    chk("mis_pc_old", PC_OLD, 64'd6);
    LOAD_IR = 1'b1;
    step();
    LOAD_IR = 1'b0;
    chk("mis_err_state", 64'(mem_req), 64'd0);
    chk("mis_sticky", 64'(misalign), 64'd1);
`else
    issue(64'd6, 32'h0000_0073);
    chk("mis_off_flag", 64'(misalign), 64'd0);
    respond(0);
    chk("mis_off_flag2", 64'(misalign), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
